// File: rtl/vy_input_sequencer.sv
// Host-to-core input sequencer for dilithium verify: splits one flat host word stream into fields and collects the verdict.
// Optional cycle counter output `cycles` enabled by defining VY_SEQ_PERF_CNT_EN.
module vy_input_sequencer #(
  parameter int unsigned W      = 64,
  parameter int unsigned MLEN_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    sec_lvl,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic [W-1:0]  h_data,
  output logic          c_start,
  output logic          c_valid,
  input  logic          c_ready,
  output logic [W-1:0]  c_data,
  input  logic          r_valid,
  output logic          r_ready,
  input  logic [W-1:0]  r_data,
  output logic          done,
  output logic          accept,
  output logic          busy,
  output logic          err
`ifdef VY_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]   cycles
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_RHO, S_C, S_Z, S_T1, S_MLEN, S_MSG, S_H, S_RESULT, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  lvl_q;
  logic [63:0] cnt_q;
  logic [63:0] msg_words_q;
  logic [63:0] field_len;
  logic [63:0] mlen64;
  logic [63:0] msg_words_nx;
  logic        in_field;
  logic        xfer;
  logic        last;
  logic        busy_q, done_q, accept_q, err_q;

  function automatic logic lvl_ok(input logic [2:0] l);
    return (l == 3'b010) || (l == 3'b011) || (l == 3'b101);
  endfunction

  assign in_field = (state == S_RHO) || (state == S_C)    || (state == S_Z)   ||
                    (state == S_T1)  || (state == S_MLEN) || (state == S_MSG) ||
                    (state == S_H);
  assign xfer     = in_field && h_valid && c_ready;
  assign last     = (cnt_q == field_len - 64'd1);

  // Word count for the message field: ceil(msg_len*8/W) in a 64-bit intermediate.
  always_comb begin
    mlen64               = '0;
    mlen64[MLEN_W-1:0]   = h_data[MLEN_W-1:0];
    msg_words_nx         = ((mlen64 << 3) + 64'(W - 1)) / 64'(W);
  end

  always_comb begin
    field_len = 64'd1;
    case (state)
      S_RHO, S_C: field_len = 64'd4;
      S_Z:        field_len = (lvl_q == 3'b010) ? 64'd288 : (lvl_q == 3'b011) ? 64'd400 : 64'd560;
      S_T1:       field_len = (lvl_q == 3'b010) ? 64'd160 : (lvl_q == 3'b011) ? 64'd240 : 64'd320;
      S_MLEN:     field_len = 64'd1;
      S_MSG:      field_len = msg_words_q;
      S_H:        field_len = (lvl_q == 3'b011) ? 64'd8 : 64'd11;
      default:    field_len = 64'd1;
    endcase
  end

  always_comb begin
    state_nx = state;
    h_ready  = 1'b0;
    c_valid  = 1'b0;
    case (state)
      S_IDLE:   if (h_valid) state_nx = lvl_ok(sec_lvl) ? S_START : S_ERR;
      S_START:  state_nx = S_RHO;
      S_RHO, S_C, S_Z, S_T1, S_MLEN, S_MSG, S_H: begin
        c_valid = h_valid;
        h_ready = c_ready;
        if (xfer && last) begin
          case (state)
            S_RHO:   state_nx = S_C;
            S_C:     state_nx = S_Z;
            S_Z:     state_nx = S_T1;
            S_T1:    state_nx = S_MLEN;
            S_MLEN:  state_nx = (msg_words_nx == 64'd0) ? S_H : S_MSG;
            S_MSG:   state_nx = S_H;
            default: state_nx = S_RESULT;
          endcase
        end
      end
      S_RESULT: if (r_valid) state_nx = S_IDLE;
      S_ERR:    h_ready = 1'b1;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      lvl_q       <= '0;
      cnt_q       <= '0;
      msg_words_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      accept_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      if (state == S_IDLE && h_valid) begin
        lvl_q <= sec_lvl;
        if (lvl_ok(sec_lvl)) busy_q <= 1'b1;
        else                 err_q  <= 1'b1;
      end
      if (xfer) cnt_q <= last ? '0 : cnt_q + 64'd1;
      if (state == S_MLEN && xfer) msg_words_q <= msg_words_nx;
      if (state == S_RESULT && r_valid) begin
        accept_q <= (r_data != '0);
        done_q   <= 1'b1;
        busy_q   <= 1'b0;
      end
    end
  end

  assign c_start = (state == S_START);
  assign r_ready = (state == S_RESULT);
  assign c_data  = in_field ? h_data : '0;
  assign done    = done_q;
  assign accept  = accept_q;
  assign busy    = busy_q;
  assign err     = err_q;

`ifdef VY_SEQ_PERF_CNT_EN
  // busy drops together with done, so the count freezes there until the next start.
  always_ff @(posedge clk) begin
    if (rst)                          cycles <= '0;
    else if (c_start)                 cycles <= '0;
    else if (busy_q && cycles != '1)  cycles <= cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vy_input_sequencer.sv
// Scoreboard bench for vy_input_sequencer: driver queues expected core words/verdicts, a negedge monitor checks them.
module tb_vy_input_sequencer;
  localparam int unsigned W = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    sec_lvl = 3'b010;
  logic          h_valid = 1'b0;
  logic          h_ready;
  logic [W-1:0]  h_data = '0;
  logic          c_start;
  logic          c_valid;
  logic          c_ready = 1'b1;
  logic [W-1:0]  c_data;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [W-1:0]  r_data = '0;
  logic          done;
  logic          accept;
  logic          busy;
  logic          err;
`ifdef VY_SEQ_PERF_CNT_EN
  logic [31:0]   cycles;
`endif

  vy_input_sequencer #(.W(W), .MLEN_W(64)) dut (
    .clk(clk), .rst(rst), .sec_lvl(sec_lvl),
    .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data),
    .c_start(c_start), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .done(done), .accept(accept), .busy(busy), .err(err)
`ifdef VY_SEQ_PERF_CNT_EN
    , .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0, errors = 0;
  logic [W-1:0] exp_q[$];
  bit           acc_q[$];
  int unsigned  cnt_q[$];
  int unsigned  cyc = 0, xfers = 0, starts = 0, dones = 0, exp_starts = 0;
  int unsigned  t0 = 0, perf_exp = 0;
  int unsigned  cr_stall = 0, hold_low = 0;
  logic         done_prev = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_evt(string name);
    checks++;
    errors++;
    $display("FAIL %s actual=expired required=event", name);
  endfunction

  // Field sizes for z, t1, h by security level.
  function automatic int unsigned fsize(int unsigned lvl, int unsigned f);
    int unsigned z, t1, h;
    case (lvl)
      2:       begin z = 288; t1 = 160; h = 11; end
      3:       begin z = 400; t1 = 240; h = 8;  end
      default: begin z = 560; t1 = 320; h = 11; end
    endcase
    return (f == 0) ? z : (f == 1) ? t1 : h;
  endfunction

  function automatic int unsigned total_words(int unsigned lvl, longint unsigned mlen);
    return 4 + 4 + fsize(lvl, 0) + fsize(lvl, 1) + 1 + int'((mlen + 7) / 8) + fsize(lvl, 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core-side ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_low > 0) begin
        c_ready = 1'b0;
        hold_low--;
      end else begin
        c_ready = ($urandom_range(99) >= cr_stall);
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      cnt_q.delete();
      xfers = 0;
    end else begin
      if (c_valid && c_ready) begin
        if (exp_q.size() == 0) fail_evt("extra_core_word");
        else chk("c_data", c_data, exp_q.pop_front());
        xfers++;
      end
      if (c_start) begin
        starts++;
        chk("c_valid_in_start", {63'd0, c_valid}, 64'd0);
        t0 = cyc;
      end
      if (done) begin
        dones++;
        chk("done_single_pulse", {63'd0, done_prev}, 64'd0);
        if (acc_q.size() == 0) fail_evt("unexpected_done");
        else begin
          chk("accept", {63'd0, accept}, {63'd0, acc_q.pop_front()});
          chk("transfer_count", xfers, cnt_q.pop_front());
          chk("words_left", exp_q.size(), 0);
        end
        xfers = 0;
`ifdef VY_SEQ_PERF_CNT_EN
        perf_exp = cyc - t0 - 1;
        chk("cycles_at_done", cycles, perf_exp);
`endif
      end
    end
    done_prev = done;
  end

  task automatic send_test(input int unsigned lvl, input longint unsigned mlen, input bit acc,
                           input int unsigned stall, input int unsigned abort_at,
                           input int unsigned stuck_at);
    logic [W-1:0] words[$];
    int unsigned  n, idx_ml, to, d0;
    bit           hs, ok;
    n      = total_words(lvl, mlen);
    idx_ml = 8 + fsize(lvl, 0) + fsize(lvl, 1);
    for (int unsigned i = 0; i < n; i++) begin
      if (i == idx_ml) words.push_back(mlen);
      else             words.push_back({$urandom, $urandom});
    end
    foreach (words[i]) exp_q.push_back(words[i]);
    acc_q.push_back(acc);
    cnt_q.push_back(n);
    exp_starts++;
    sec_lvl  = 3'(lvl);
    cr_stall = stall;
    for (int unsigned i = 0; i < n; i++) begin
      if (i == abort_at) begin
        rst     = 1'b1;
        h_valid = 1'b0;
        tick();
        rst      = 1'b0;
        cr_stall = 0;
        return;
      end
      if (i == stuck_at) hold_low = 10;
      while ($urandom_range(99) < stall) begin
        h_valid = 1'b0;
        tick();
      end
      h_valid = 1'b1;
      h_data  = words[i];
      ok = 1'b0;
      to = 0;
      while (!ok) begin
        @(negedge clk);
        hs = h_ready;
        @(posedge clk);
        #1;
        if (hs) ok = 1'b1;
        else if (++to > 2000) begin
          fail_evt("host_word_accept");
          h_valid = 1'b0;
          return;
        end
      end
    end
    h_valid  = 1'b0;
    cr_stall = 0;
    to = 0;
    while (!r_ready && to < 100) begin
      tick();
      to++;
    end
    if (!r_ready) begin
      fail_evt("result_phase");
      return;
    end
    repeat ($urandom_range(3)) tick();
    d0      = dones;
    r_valid = 1'b1;
    r_data  = acc ? ({$urandom, $urandom} | 64'd1) : '0;
    tick();
    r_valid = 1'b0;
    to = 0;
    while (dones == d0 && to < 5) begin
      tick();
      to++;
    end
    if (dones == d0) fail_evt("done_pulse");
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("start_count", starts, exp_starts);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_h_ready"}, {63'd0, h_ready}, 64'd0);
    chk({tag, "_c_valid"}, {63'd0, c_valid}, 64'd0);
    chk({tag, "_c_start"}, {63'd0, c_start}, 64'd0);
    chk({tag, "_r_ready"}, {63'd0, r_ready}, 64'd0);
    chk({tag, "_done"},    {63'd0, done},    64'd0);
    chk({tag, "_accept"},  {63'd0, accept},  64'd0);
    chk({tag, "_busy"},    {63'd0, busy},    64'd0);
    chk({tag, "_err"},     {63'd0, err},     64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0;
    longint unsigned ml;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_all_zero("reset");

    send_test(2, 33, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_test(5, 0, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      ml = $urandom_range(0, 100);
      send_test(3, ml, 1'($urandom_range(1)), 50, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    end
    send_test(2, 33, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Invalid level: error state drains host words, core never started.
    s0      = starts;
    sec_lvl = 3'b100;
    h_valid = 1'b1;
    h_data  = {$urandom, $urandom};
    repeat (3) tick();
    chk("err_set", {63'd0, err}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      h_data = {$urandom, $urandom};
      chk("err_drain_h_ready", {63'd0, h_ready}, 64'd1);
      tick();
    end
    h_valid = 1'b0;
    chk("err_no_start", starts, s0);
    chk("err_not_busy", {63'd0, busy}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", {63'd0, err}, 64'd0);
    send_test(2, 33, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Reset during the z field, then a clean run.
    send_test(2, 33, 1'b1, 0, 8 + 100, 32'hFFFF_FFFF);
    check_all_zero("midrst");
    tick();
    send_test(2, 33, 1'b1, 0, 32'hFFFF_FFFF, 200);
`ifdef VY_SEQ_PERF_CNT_EN
    repeat (5) tick();
    chk("cycles_hold", cycles, perf_exp);
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
